psram_responder: RTL and testbench

Synthesizable, cycle-level model of one 4-bit QPI PSRAM device: the responder end of the PSRAM bus. It decodes SPI-mode command 35h (enter QPI), QPI commands EBh (quad read with wait cycles), 38h (quad write) and F5h (exit QPI), all backed by on-chip byte memory. It sits on the chip side of the PSRAM pins for on-FPGA loopback testing of the controller. Two instances, on data nibbles [3:0] and [7:4], emulate the dual-chip bus.

---
 rtl/psram_responder_if.sv | 21 ++
 rtl/psram_responder.sv | 216 +++++++++++++++++++++
 tb/tb_psram_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/psram_responder_if.sv
// Pin-level bundle between a PSRAM host (master) and the QPI PSRAM responder (slave).
// Signal names follow the device pin view: i_* are driven by the host, o_* by the responder.
interface psram_responder_if;
  logic       i_csn;
  logic       i_sclk_en;
  logic [3:0] i_data;
  logic [3:0] o_data;
  logic       o_oe;
  logic       o_qpi;
  logic       o_cmd_err;

  modport master (
    output i_csn, i_sclk_en, i_data,
    input  o_data, o_oe, o_qpi, o_cmd_err
  );

  modport slave (
    input  i_csn, i_sclk_en, i_data,
    output o_data, o_oe, o_qpi, o_cmd_err
  );
endinterface

// File: rtl/psram_responder.sv
// Cycle-level model of one 4-bit QPI PSRAM chip: SPI 35h entry, QPI EBh/38h/F5h, on-chip byte memory.
// WAIT_CYCLES must be at least 1 so the first read byte is fetched before o_data is loaded.
module psram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 6
) (
  input logic           i_clk,
  input logic           i_rst,
  psram_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RDATA  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  state_t                 state_r, state_s;
  logic [7:0]             cnt_r, cnt_s;
  logic [6:0]             op_r, op_s;
  logic [ADDR_BITS-1:0]   addr_r, addr_s;
  logic [ADDR_BITS-1:0]   ptr_r, ptr_s;
  logic                   is_rd_r, is_rd_s;
  logic [3:0]             wr_hi_r, wr_hi_s;
  logic [3:0]             data_r, data_s;
  logic                   oe_r, oe_s;
  logic                   qpi_r, qpi_s;
  logic                   err_r, err_s;
  logic                   we_s;
  logic [7:0]             wbyte_s;
  logic [ADDR_BITS-1:0]   rd_addr_s;
  logic [7:0]             rd_byte_r;
  logic [7:0]             mem_r [0:(2**ADDR_BITS)-1];

  logic                   bus_cyc_s;
  logic [7:0]             op_spi_s;
  logic [7:0]             op_qpi_s;
  logic [ADDR_BITS-1:0]   addr_next_s;
  logic [ADDR_BITS-1:0]   ptr_inc_s;

  // Only the low ADDR_BITS of the 24-bit address survive the nibble shift.
  assign bus_cyc_s   = !bus.i_csn && bus.i_sclk_en;
  assign op_spi_s    = {op_r, bus.i_data[0]};
  assign op_qpi_s    = {op_r[3:0], bus.i_data};
  assign addr_next_s = {addr_r[ADDR_BITS-5:0], bus.i_data};
  assign ptr_inc_s   = ptr_r + ADDR_BITS'(1);

  // Next-state and output decode for one bus cycle.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    op_s      = op_r;
    addr_s    = addr_r;
    ptr_s     = ptr_r;
    is_rd_s   = is_rd_r;
    wr_hi_s   = wr_hi_r;
    data_s    = data_r;
    oe_s      = oe_r;
    qpi_s     = qpi_r;
    err_s     = 1'b0;
    we_s      = 1'b0;
    wbyte_s   = {wr_hi_r, bus.i_data};
    rd_addr_s = ptr_r;
    if (bus.i_csn) begin
      state_s = ST_CMD;
      cnt_s   = 8'd0;
      oe_s    = 1'b0;
    end else if (bus.i_sclk_en) begin
      case (state_r)
        ST_CMD: begin
          if (!qpi_r) begin
            op_s = op_spi_s[6:0];
            if (cnt_r == 8'd7) begin
              if (op_spi_s == 8'h35) begin
                qpi_s = 1'b1;
              end else begin
                err_s = 1'b1;
              end
              state_s = ST_IGNORE;
              cnt_s   = 8'd0;
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            op_s = op_qpi_s[6:0];
            if (cnt_r == 8'd1) begin
              cnt_s = 8'd0;
              case (op_qpi_s)
                8'hEB: begin
                  state_s = ST_ADDR;
                  is_rd_s = 1'b1;
                end
                8'h38: begin
                  state_s = ST_ADDR;
                  is_rd_s = 1'b0;
                end
                8'hF5: begin
                  state_s = ST_IGNORE;
                  qpi_s   = 1'b0;
                end
                default: begin
                  state_s = ST_IGNORE;
                  err_s   = 1'b1;
                end
              endcase
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end
        end
        ST_ADDR: begin
          addr_s    = addr_next_s;
          rd_addr_s = addr_next_s;
          if (cnt_r == 8'd5) begin
            ptr_s   = addr_next_s;
            cnt_s   = 8'd0;
            state_s = is_rd_r ? ST_WAIT : ST_WDATA;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        ST_WAIT: begin
          if (cnt_r == WAIT_LAST) begin
            oe_s    = 1'b1;
            data_s  = rd_byte_r[7:4];
            state_s = ST_RDATA;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        ST_RDATA: begin
          // Low nibble goes out while the next byte is prefetched.
          if (cnt_r[0] == 1'b0) begin
            data_s    = rd_byte_r[3:0];
            ptr_s     = ptr_inc_s;
            rd_addr_s = ptr_inc_s;
            cnt_s     = 8'd1;
          end else begin
            data_s = rd_byte_r[7:4];
            cnt_s  = 8'd0;
          end
        end
        ST_WDATA: begin
          if (cnt_r[0] == 1'b0) begin
            wr_hi_s = bus.i_data;
            cnt_s   = 8'd1;
          end else begin
            we_s  = 1'b1;
            ptr_s = ptr_inc_s;
            cnt_s = 8'd0;
          end
        end
        ST_IGNORE: begin
          state_s = ST_IGNORE;
        end
        default: begin
          state_s = ST_CMD;
          cnt_s   = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_CMD;
      cnt_r   <= 8'd0;
      op_r    <= 7'd0;
      addr_r  <= '0;
      ptr_r   <= '0;
      is_rd_r <= 1'b0;
      wr_hi_r <= 4'd0;
      data_r  <= 4'd0;
      oe_r    <= 1'b0;
      qpi_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      addr_r  <= addr_s;
      ptr_r   <= ptr_s;
      is_rd_r <= is_rd_s;
      wr_hi_r <= wr_hi_s;
      data_r  <= data_s;
      oe_r    <= oe_s;
      qpi_r   <= qpi_s;
      err_r   <= err_s;
    end
  end

  // Byte memory with registered read port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (we_s && !i_rst) begin
      mem_r[ptr_r] <= wbyte_s;
    end
    if (bus_cyc_s) begin
      rd_byte_r <= mem_r[rd_addr_s];
    end
  end

  assign bus.o_data    = data_r;
  assign bus.o_oe      = oe_r;
  assign bus.o_qpi     = qpi_r;
  assign bus.o_cmd_err = err_r;

endmodule

// File: tb/tb_psram_responder.sv
// Scoreboard bench for psram_responder: a host model drives transactions, read data is
// predicted from a byte-memory model, queued, and compared as the responder drives it.
module tb_psram_responder;
  localparam int AB = 12;
  localparam int W  = 6;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [7:0] model [0:(2**AB)-1];
  logic [3:0] rd_q [$];

  psram_responder_if bus ();

  psram_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one clock period's inputs; outputs sampled afterwards reflect the previous edge.
  task automatic cyc(input logic csn, input logic en, input logic [3:0] d);
    @(negedge clk);
    bus.i_csn     = csn;
    bus.i_sclk_en = en;
    bus.i_data    = d;
    #1;
  endtask

  task automatic deselect();
    cyc(1'b1, 1'b1, 4'h0);
    chk("desel_err0", bus.o_cmd_err, 1'b0);
    cyc(1'b1, 1'b1, 4'h0);
    chk("desel_oe", bus.o_oe, 1'b0);
    chk("desel_err1", bus.o_cmd_err, 1'b0);
  endtask

  task automatic enter_qpi();
    logic [7:0] op;
    op = 8'h35;
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b1, {3'b000, op[i]});
      chk("spi_qpi", bus.o_qpi, 1'b0);
      chk("spi_err", bus.o_cmd_err, 1'b0);
    end
    cyc(1'b1, 1'b1, 4'h0);
    chk("qpi_k7", bus.o_qpi, 1'b1);
    chk("qpi_err", bus.o_cmd_err, 1'b0);
    deselect();
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] nib_v, input int n);
    logic [3:0]  cn [8];
    logic [3:0]  d;
    logic [AB-1:0] p;
    cn[0] = 4'h3;
    cn[1] = 4'h8;
    for (int i = 0; i < 6; i++) cn[2+i] = a[23-4*i -: 4];
    for (int k = 0; k < 8 + n; k++) begin
      d = (k < 8) ? cn[k] : nib_v[31-4*(k-8) -: 4];
      cyc(1'b0, 1'b1, d);
      chk("wr_oe", bus.o_oe, 1'b0);
    end
    p = a[AB-1:0];
    for (int b = 0; b < n / 2; b++) begin
      model[p] = nib_v[31-8*b -: 8];
      p = p + 12'd1;
    end
    deselect();
  endtask

  task automatic do_read(input logic [23:0] a, input int nbytes, input int stall_k,
                         input int stall_n, input int abort_k, input bit by_rst);
    logic [AB-1:0] p;
    logic [3:0]    cn [8];
    logic [3:0]    e;
    int k, clk_i, first_oe, stall_left;
    p = a[AB-1:0];
    rd_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      rd_q.push_back(model[p][7:4]);
      rd_q.push_back(model[p][3:0]);
      p = p + 12'd1;
    end
    cn[0] = 4'hE;
    cn[1] = 4'hB;
    for (int i = 0; i < 6; i++) cn[2+i] = a[23-4*i -: 4];
    k = 0; clk_i = 0; first_oe = -1; stall_left = stall_n;
    while (k < 8 + W + 2 * nbytes && k != abort_k) begin
      if (k == stall_k && stall_left > 0) begin
        cyc(1'b0, 1'b0, 4'h0);
        chk("stall_oe", bus.o_oe, 1'b0);
        stall_left--;
      end else begin
        cyc(1'b0, 1'b1, (k < 8) ? cn[k] : 4'h0);
        chk("rd_oe", bus.o_oe, (k >= 8 + W));
        if (bus.o_oe === 1'b1 && first_oe < 0) first_oe = clk_i;
        if (k >= 8 + W) begin
          e = rd_q.pop_front();
          chk("rdata", bus.o_data, e);
        end
        k++;
      end
      clk_i++;
    end
    if (abort_k < 0) begin
      chk("oe_rise_clk", first_oe, 8 + W + stall_n);
      chk("rd_q_empty", rd_q.size(), 0);
    end
    if (by_rst) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      bus.i_csn = 1'b1;
      #1;
      chk("rst_oe", bus.o_oe, 1'b0);
      chk("rst_qpi", bus.o_qpi, 1'b0);
      chk("rst_data", bus.o_data, 4'h0);
    end
    deselect();
    rd_q.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 2**AB; i++) model[i] = 8'h00;
    rst = 1'b1;
    bus.i_csn = 1'b1;
    bus.i_sclk_en = 1'b0;
    bus.i_data = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_o_data", bus.o_data, 4'h0);
    chk("rst_o_oe", bus.o_oe, 1'b0);
    chk("rst_o_qpi", bus.o_qpi, 1'b0);
    chk("rst_o_err", bus.o_cmd_err, 1'b0);

    enter_qpi();
    do_write(24'h000010, 32'hABCD_0000, 4);
    do_read(24'h000010, 2, -1, 0, -1, 1'b0);

    do_write(24'h000FFF, 32'h1122_0000, 4);
    do_read(24'h000000, 1, -1, 0, -1, 1'b0);
    do_read(24'h000FFF, 2, -1, 0, -1, 1'b0);

    do_write(24'h000020, 32'h009A_0000, 4);
    do_write(24'h000020, 32'h5670_0000, 3);
    do_read(24'h000020, 2, -1, 0, -1, 1'b0);

    do_read(24'h000010, 2, -1, 0, 10, 1'b0);
    do_read(24'h000010, 2, -1, 0, 15, 1'b0);
    do_read(24'h000010, 2, 9, 3, -1, 1'b0);
    do_read(24'hABC010, 1, -1, 0, -1, 1'b0);

    // Unsupported QPI opcode 12h
    cyc(1'b0, 1'b1, 4'h1);
    chk("bad_err_k0", bus.o_cmd_err, 1'b0);
    cyc(1'b0, 1'b1, 4'h2);
    chk("bad_err_k1", bus.o_cmd_err, 1'b0);
    cyc(1'b0, 1'b1, 4'h0);
    chk("bad_err_pulse", bus.o_cmd_err, 1'b1);
    cyc(1'b0, 1'b1, 4'h0);
    chk("bad_err_clear", bus.o_cmd_err, 1'b0);
    deselect();
    do_read(24'h000010, 2, -1, 0, -1, 1'b0);

    // Exit QPI with F5h
    cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b0, 1'b1, 4'h5);
    cyc(1'b1, 1'b1, 4'h0);
    chk("qpi_off", bus.o_qpi, 1'b0);
    deselect();

    enter_qpi();
    do_read(24'h000010, 2, -1, 0, 16, 1'b1);
    enter_qpi();
    do_read(24'h000010, 2, -1, 0, -1, 1'b0);
    do_read(24'h000FFF, 2, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
